// File: rtl/ws2812_pkg.sv
// Shared types, default timing and helper for the WS2812 serial LED driver.
// Byte order is selected by WS2812_GRB_ORDER_EN in the top level.
package ws2812_pkg;

    typedef enum logic {
        LATCH = 1'b0,
        BIT   = 1'b1
    } state_t;

    localparam int T0H_CYC_DEF = 20;
    localparam int T1H_CYC_DEF = 40;
    localparam int BIT_CYC_DEF = 63;
    localparam int RES_CYC_DEF = 2500;

    localparam int FRAME_BITS = 24;

    // Width needed to hold the larger of the bit and latch periods; never below 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle timer: counts one bit period, produces the registered-next line
// level for the current bit value and flags the last cycle of the bit.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = T0H_CYC_DEF,
    parameter int T1H_CYC = T1H_CYC_DEF,
    parameter int BIT_CYC = BIT_CYC_DEF,
    parameter int CW      = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic run_i,
    input  logic bit_i,
    output logic level_o,
    output logic done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        done_o = (cnt_q == CW'(BIT_CYC - 1));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = done_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Level is evaluated on the next count so the line register matches the counter
    // cycle for cycle; a fresh bit (count 0) is therefore always high.
    always_comb begin
        if (bit_i) begin
            level_o = (cnt_d < CW'(T1H_CYC));
        end else begin
            level_o = (cnt_d < CW'(T0H_CYC));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_led_driver.sv
// WS2812 single-wire encoder: refreshes one LED continuously from rgb_data.
// Define WS2812_GRB_ORDER_EN to transmit in native G,R,B byte order; otherwise R,G,B.
module ws2812_led_driver
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = T0H_CYC_DEF,
    parameter int T1H_CYC = T1H_CYC_DEF,
    parameter int BIT_CYC = BIT_CYC_DEF,
    parameter int RES_CYC = RES_CYC_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] rgb_data,
    output logic        DATA
);

    localparam int CW = cnt_width(BIT_CYC, RES_CYC);

    state_t        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    idx_q, idx_d;
    logic          data_q, data_d;
    logic [23:0]   load_word;

    logic tmr_start;
    logic tmr_run;
    logic tmr_level;
    logic tmr_done;

`ifdef WS2812_GRB_ORDER_EN
    assign load_word = {rgb_data[15:8], rgb_data[23:16], rgb_data[7:0]};
`else
    assign load_word = rgb_data;
`endif

    ws2812_bit_timer #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC),
        .CW      (CW)
    ) u_bit_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (tmr_start),
        .run_i   (tmr_run),
        .bit_i   (shift_q[23]),
        .level_o (tmr_level),
        .done_o  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        data_d    = 1'b0;
        tmr_start = 1'b0;
        tmr_run   = 1'b0;
        case (state_q)
            LATCH: begin
                if (lat_q == CW'(RES_CYC - 1)) begin
                    state_d   = BIT;
                    shift_d   = load_word;
                    idx_d     = 5'(FRAME_BITS - 1);
                    tmr_start = 1'b1;
                    data_d    = tmr_level;
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            BIT: begin
                tmr_run = 1'b1;
                data_d  = tmr_level;
                if (tmr_done) begin
                    if (idx_q == 5'd0) begin
                        state_d = LATCH;
                        lat_d   = '0;
                        data_d  = 1'b0;
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        idx_d   = idx_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = LATCH;
                lat_d   = CW'(RES_CYC - 1);
            end
        endcase
    end

    // Latch counter resets to terminal so the first edge after reset starts a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LATCH;
            lat_q   <= CW'(RES_CYC - 1);
            shift_q <= '0;
            idx_q   <= 5'd0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign DATA = data_q;

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Directed self-checking bench for ws2812_led_driver (default and shrunk timing).
module tb_ws2812_led_driver;

    localparam int T0 = 20, T1 = 40, BC = 63, RC = 2500;
    localparam int S0 = 2, S1 = 4, SB = 6, SR = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_s;
    logic [23:0] rgb;
    logic [23:0] rgb_s;
    logic        data_l;
    logic        data_s;

    int n_cmp = 0;
    int n_err = 0;
    int hi_w[24];
    int per_w[24];

    always #5 clk = ~clk;

    ws2812_led_driver dut (
        .CLK      (clk),
        .RST      (rst),
        .rgb_data (rgb),
        .DATA     (data_l)
    );

    ws2812_led_driver #(
        .T0H_CYC (S0),
        .T1H_CYC (S1),
        .BIT_CYC (SB),
        .RES_CYC (SR)
    ) dut_s (
        .CLK      (clk),
        .RST      (rst_s),
        .rgb_data (rgb_s),
        .DATA     (data_s)
    );

    function automatic logic [23:0] wire_order(input logic [23:0] c);
`ifdef WS2812_GRB_ORDER_EN
        return {c[15:8], c[23:16], c[7:0]};
`else
        return c;
`endif
    endfunction

    function automatic logic line(input bit sel);
        return sel ? data_s : data_l;
    endfunction

    // Starts at the first high cycle of a frame; ends at the first high cycle of the next.
    task automatic measure(input bit sel);
        for (int b = 0; b < 24; b++) begin
            int h = 0;
            int l = 0;
            while (line(sel) === 1'b1 && h < 5000) begin
                h++;
                @(negedge clk);
            end
            while (line(sel) !== 1'b1 && l < 5000) begin
                l++;
                @(negedge clk);
            end
            hi_w[b]  = h;
            per_w[b] = h + l;
        end
    endtask

    task automatic restart(input bit sel);
        if (sel) rst_s = 1'b1; else rst = 1'b1;
        repeat (2) @(negedge clk);
        if (sel) rst_s = 1'b0; else rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rgb = 24'hAAAAAA;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (data_l !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: DATA=%b expected 0", data_l);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (data_l !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: DATA=%b expected 0", i, data_l);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_l !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_edge: DATA=%b expected 1", data_l);
        end
    endtask

    task automatic test_pattern_aa;
        logic [23:0] w;
        int sum;
        w = wire_order(24'hAAAAAA);
        for (int f = 0; f < 2; f++) begin
            measure(1'b0);
            sum = 0;
            for (int b = 0; b < 24; b++) begin
                int eh, ep;
                eh = w[23-b] ? T1 : T0;
                ep = (b == 23) ? BC + RC : BC;
                sum += per_w[b];
                n_cmp++;
                if (hi_w[b] !== eh) begin
                    n_err++;
                    $display("FAIL aa_hi f%0d b%0d: got %0d expected %0d", f, b, hi_w[b], eh);
                end
                n_cmp++;
                if (per_w[b] !== ep) begin
                    n_err++;
                    $display("FAIL aa_period f%0d b%0d: got %0d expected %0d", f, b, per_w[b], ep);
                end
            end
            n_cmp++;
            if (sum !== 4012) begin
                n_err++;
                $display("FAIL aa_frame f%0d: got %0d expected 4012", f, sum);
            end
        end
    endtask

    task automatic test_byte_order;
        logic [23:0] w;
        rgb = 24'hFF0000;
        restart(1'b0);
        measure(1'b0);
        w = wire_order(24'hFF0000);
        for (int b = 0; b < 24; b++) begin
            int eh;
            eh = w[23-b] ? T1 : T0;
            n_cmp++;
            if (hi_w[b] !== eh) begin
                n_err++;
                $display("FAIL order_hi b%0d: got %0d expected %0d", b, hi_w[b], eh);
            end
        end
    endtask

    task automatic test_mid_frame_change;
        rgb = 24'h000000;
        restart(1'b0);
        fork
            begin
                repeat (10 * BC + 5) @(negedge clk);
                rgb = 24'hFFFFFF;
            end
            measure(1'b0);
        join
        for (int b = 0; b < 24; b++) begin
            n_cmp++;
            if (hi_w[b] !== T0) begin
                n_err++;
                $display("FAIL change_cur b%0d: got %0d expected %0d", b, hi_w[b], T0);
            end
        end
        measure(1'b0);
        for (int b = 0; b < 24; b++) begin
            n_cmp++;
            if (hi_w[b] !== T1) begin
                n_err++;
                $display("FAIL change_next b%0d: got %0d expected %0d", b, hi_w[b], T1);
            end
        end
    endtask

    task automatic test_reset_mid_bit;
        logic [23:0] w;
        int sum;
        rgb = 24'hAAAAAA;
        w = wire_order(24'hAAAAAA);
        restart(1'b0);
        repeat (18 * BC + 30) @(negedge clk);
        n_cmp++;
        if (data_l !== 1'b1) begin
            n_err++;
            $display("FAIL midbit_pre: DATA=%b expected 1", data_l);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (data_l !== 1'b0) begin
            n_err++;
            $display("FAIL midbit_async: DATA=%b expected 0", data_l);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        measure(1'b0);
        sum = 0;
        for (int b = 0; b < 24; b++) begin
            int eh;
            eh = w[23-b] ? T1 : T0;
            sum += per_w[b];
            n_cmp++;
            if (hi_w[b] !== eh) begin
                n_err++;
                $display("FAIL midbit_restart b%0d: got %0d expected %0d", b, hi_w[b], eh);
            end
        end
        n_cmp++;
        if (sum !== 4012) begin
            n_err++;
            $display("FAIL midbit_frame: got %0d expected 4012", sum);
        end
    endtask

    task automatic test_small_params;
        logic [23:0] w;
        int sum;
        rgb_s = 24'h800001;
        w = wire_order(24'h800001);
        restart(1'b1);
        measure(1'b1);
        sum = 0;
        for (int b = 0; b < 24; b++) begin
            int eh, ep;
            eh = w[23-b] ? S1 : S0;
            ep = (b == 23) ? SB + SR : SB;
            sum += per_w[b];
            n_cmp++;
            if (hi_w[b] !== eh) begin
                n_err++;
                $display("FAIL small_hi b%0d: got %0d expected %0d", b, hi_w[b], eh);
            end
            n_cmp++;
            if (per_w[b] !== ep) begin
                n_err++;
                $display("FAIL small_period b%0d: got %0d expected %0d", b, per_w[b], ep);
            end
        end
        n_cmp++;
        if (sum !== 154) begin
            n_err++;
            $display("FAIL small_frame: got %0d expected 154", sum);
        end
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        rgb   = 24'h000000;
        rgb_s = 24'h000000;
        test_reset;
        test_pattern_aa;
        test_byte_order;
        test_mid_frame_change;
        test_reset_mid_bit;
        test_small_params;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
